vga_sync_monitor: RTL and testbench



---
 rtl/vga_sync_monitor.sv | 164 ++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - measures hsync/vsync timing and declares lock after two identical frames
// Optional: define VGA_SYNC_MON_TOLERANCE_EN to accept +/-1 cycle on h_total compares.
module vga_sync_monitor #(
  parameter int HWIDTH    = 12,
  parameter int VWIDTH    = 11,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  output logic              locked,
  output logic              lock_lost,
  output logic [HWIDTH-1:0] h_total,
  output logic [HWIDTH-1:0] h_sync_width,
  output logic [VWIDTH-1:0] v_total,
  output logic [VWIDTH-1:0] v_sync_width
);

  typedef enum logic [1:0] {SEARCH, MEASURE, VERIFY, LOCKED} state_t;

  localparam logic [HWIDTH-1:0] HMAX  = '1;
  localparam logic [VWIDTH-1:0] VMAX  = '1;
  localparam logic [HWIDTH-1:0] H_ONE = {{(HWIDTH-1){1'b0}}, 1'b1};
  localparam logic [VWIDTH-1:0] V_ONE = {{(VWIDTH-1){1'b0}}, 1'b1};

  state_t            state;
  logic              hs_r, vs_r, hs_prev, vs_prev;
  logic              hs_lead, hs_trail, vs_lead, vs_trail;
  logic [HWIDTH-1:0] h_cnt, hw_cnt, h_line, h_width, h_len_now;
  logic [VWIDTH-1:0] v_cnt, vw_cnt, v_width, v_cap;
  logic [HWIDTH-1:0] ref_h_total, ref_h_width;
  logic [VWIDTH-1:0] ref_v_total, ref_v_width;
  logic              timeout, rec_match, lock_mismatch;

  function automatic logic h_equal(input logic [HWIDTH-1:0] a, input logic [HWIDTH-1:0] b);
`ifdef VGA_SYNC_MON_TOLERANCE_EN
    h_equal = (a == b) || (a == b + H_ONE) || (a + H_ONE == b);
`else
    h_equal = (a == b);
`endif
  endfunction

  assign hs_lead  = hs_r & ~hs_prev;
  assign hs_trail = ~hs_r & hs_prev;
  assign vs_lead  = vs_r & ~vs_prev;
  assign vs_trail = ~vs_r & vs_prev;

  // A coincident hsync edge still belongs to the frame that is closing.
  assign h_len_now = (h_cnt == HMAX) ? HMAX : h_cnt + H_ONE;
  assign v_cap     = v_cnt + (hs_lead ? V_ONE : '0);
  assign timeout   = (h_cnt == HMAX) || (v_cnt == VMAX);

  assign rec_match = h_equal(h_line, ref_h_total) && (h_width == ref_h_width) &&
                     (v_cap == ref_v_total) && (v_width == ref_v_width);

  assign lock_mismatch = (hs_lead && !h_equal(h_len_now, h_total)) ||
                         (hs_trail && (hw_cnt != h_sync_width)) ||
                         (vs_lead && ((v_cap != v_total) || (v_width != v_sync_width)));

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      h_cnt   <= '0;
      hw_cnt  <= '0;
      h_line  <= '0;
      h_width <= '0;
      v_cnt   <= '0;
      vw_cnt  <= '0;
      v_width <= '0;
    end else begin
      hs_r    <= (hsync == HSYNC_POL);
      vs_r    <= (vsync == VSYNC_POL);
      hs_prev <= hs_r;
      vs_prev <= vs_r;

      if (hs_lead) begin
        h_line <= h_len_now;
        h_cnt  <= '0;
      end else if (h_cnt != HMAX) begin
        h_cnt <= h_cnt + H_ONE;
      end

      if (hs_lead) hw_cnt <= H_ONE;
      else if (hs_r && (hw_cnt != HMAX)) hw_cnt <= hw_cnt + H_ONE;
      if (hs_trail) h_width <= hw_cnt;

      if (vs_lead) v_cnt <= '0;
      else if (hs_lead && (v_cnt != VMAX)) v_cnt <= v_cnt + V_ONE;

      // An hsync edge landing with the vsync edge is the first line of the pulse.
      if (vs_lead) vw_cnt <= hs_lead ? V_ONE : '0;
      else if (vs_r && hs_lead && (vw_cnt != VMAX)) vw_cnt <= vw_cnt + V_ONE;
      if (vs_trail) v_width <= vw_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEARCH;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      h_total      <= '0;
      h_sync_width <= '0;
      v_total      <= '0;
      v_sync_width <= '0;
      ref_h_total  <= '0;
      ref_h_width  <= '0;
      ref_v_total  <= '0;
      ref_v_width  <= '0;
    end else begin
      lock_lost <= 1'b0;
      if (timeout) begin
        state     <= SEARCH;
        locked    <= 1'b0;
        lock_lost <= (state == LOCKED);
      end else begin
        case (state)
          SEARCH: if (vs_lead) state <= MEASURE;
          MEASURE: begin
            if (vs_lead) begin
              ref_h_total <= h_line;
              ref_h_width <= h_width;
              ref_v_total <= v_cap;
              ref_v_width <= v_width;
              state       <= VERIFY;
            end
          end
          VERIFY: begin
            if (vs_lead) begin
              if (rec_match) begin
                // Outputs take the reference so a tolerated h jitter never moves them.
                h_total      <= ref_h_total;
                h_sync_width <= ref_h_width;
                v_total      <= ref_v_total;
                v_sync_width <= ref_v_width;
                locked       <= 1'b1;
                state        <= LOCKED;
              end else begin
                ref_h_total <= h_line;
                ref_h_width <= h_width;
                ref_v_total <= v_cap;
                ref_v_width <= v_width;
              end
            end
          end
          LOCKED: begin
            if (lock_mismatch) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - randomized sync streams checked cycle by cycle against an edge-level timing model
module tb_vga_sync_monitor;

  localparam int HSAT = 4095;
  localparam int VSAT = 2047;
  localparam logic HPOL = 1'b0;
  localparam logic VPOL = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        locked, lock_lost;
  logic [11:0] h_total, h_sync_width;
  logic [10:0] v_total, v_sync_width;

  vga_sync_monitor #(.HWIDTH(12), .VWIDTH(11), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
    .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .locked(locked), .lock_lost(lock_lost),
    .h_total(h_total), .h_sync_width(h_sync_width),
    .v_total(v_total), .v_sync_width(v_sync_width)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: works on input edge timestamps and the lock rules.
  int t = 0;
  bit m_hs_prev, m_vs_prev;
  int last_lead, lead_t, nleads, vw_run;
  int m_line, m_width, m_vw_last;
  int ref_line, ref_width, ref_vt, ref_vw;
  int nseen;
  bit m_locked, m_lost;
  int o_ht, o_hw, o_vt, o_vw;
  logic [47:0] d1, d2;
  bit armed = 1'b0;
  bit prev_rst = 1'b0;
  int lost_seen = 0;

  function automatic bit h_ok(input int a, input int b);
`ifdef VGA_SYNC_MON_TOLERANCE_EN
    return (a - b <= 1) && (b - a <= 1);
`else
    return a == b;
`endif
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [47:0] model_vec();
    return {m_locked, m_lost, 12'(o_ht), 12'(o_hw), 11'(o_vt), 11'(o_vw)};
  endfunction

  task automatic model_reset();
    m_hs_prev = 0; m_vs_prev = 0;
    last_lead = t - 1; lead_t = t; nleads = 0; vw_run = 0;
    m_line = 0; m_width = 0; m_vw_last = 0;
    ref_line = 0; ref_width = 0; ref_vt = 0; ref_vw = 0;
    nseen = 0; m_locked = 0; m_lost = 0;
    o_ht = 0; o_hw = 0; o_vt = 0; o_vw = 0;
  endtask

  task automatic model_step(input bit hs_a, input bit vs_a);
    bit hl, ht, vl, vt, tmo, rec_eq, bad;
    int gap, rv;
    hl = hs_a && !m_hs_prev;
    ht = !hs_a && m_hs_prev;
    vl = vs_a && !m_vs_prev;
    vt = !vs_a && m_vs_prev;
    gap = sat(t - last_lead, HSAT);
    tmo = (t - last_lead - 1 >= HSAT) || (nleads >= VSAT);
    rv = nleads + (hl ? 1 : 0);
    rec_eq = h_ok(m_line, ref_line) && (m_width == ref_width) && (rv == ref_vt) && (m_vw_last == ref_vw);
    bad = (hl && !h_ok(gap, o_ht)) || (ht && (sat(t - lead_t, HSAT) != o_hw)) ||
          (vl && ((rv != o_vt) || (m_vw_last != o_vw)));
    m_lost = 0;
    if (tmo) begin
      m_lost = m_locked; m_locked = 0; nseen = 0;
    end else if (m_locked) begin
      if (bad) begin m_lost = 1; m_locked = 0; nseen = 0; end
    end else if (vl) begin
      nseen++;
      if (nseen >= 3 && rec_eq) begin
        m_locked = 1;
        o_ht = ref_line; o_hw = ref_width; o_vt = ref_vt; o_vw = ref_vw;
      end else if (nseen >= 2) begin
        ref_line = m_line; ref_width = m_width; ref_vt = rv; ref_vw = m_vw_last;
      end
    end
    if (ht) m_width = sat(t - lead_t, HSAT);
    if (hl) begin m_line = gap; last_lead = t; lead_t = t; end
    if (vl) begin
      vw_run = hl ? 1 : 0; nleads = 0;
    end else begin
      if (hl) nleads = sat(nleads + 1, VSAT);
      if (vs_a && hl) vw_run++;
    end
    if (vt) m_vw_last = vw_run;
    m_hs_prev = hs_a; m_vs_prev = vs_a;
  endtask

  // DUT outputs trail the driven inputs by two clocks.
  task automatic cycle(input bit hs_a, input bit vs_a, input bit rst);
    @(negedge clk);
    if (armed && errors < 40)
      check("cycle", {locked, lock_lost, h_total, h_sync_width, v_total, v_sync_width}, d2);
    if (prev_rst)
      check("reset_clear", {locked, lock_lost, h_total, h_sync_width, v_total, v_sync_width}, 48'h0);
    if (lock_lost) lost_seen++;
    reset = rst;
    hsync = hs_a ? HPOL : ~HPOL;
    vsync = vs_a ? VPOL : ~VPOL;
    if (rst) begin
      model_reset();
      d1 = model_vec(); d2 = d1; armed = 1'b1;
    end else begin
      model_step(hs_a, vs_a);
      d2 = d1; d1 = model_vec();
    end
    prev_rst = rst;
    t++;
  endtask

  task automatic frame(input int L, input int hw, input int N, input int vsl,
                       input int d, input int stretch, input int rst_at);
    int pos, len;
    pos = 0;
    for (int ln = 0; ln < N; ln++) begin
      len = (ln == stretch) ? L + 1 : L;
      for (int c = 0; c < len; c++) begin
        cycle(c < hw, (pos >= d) && (pos < d + vsl * L), pos == rst_at);
        pos++;
      end
    end
  endtask

  int aL, aH, aN, aV, bL, bH, bN, bV, bD, lost0, exp_lost;

  initial begin
    aL = $urandom_range(30, 60); aH = $urandom_range(3, 8);
    aN = $urandom_range(10, 16); aV = $urandom_range(1, 3);
    bL = $urandom_range(30, 60); bH = $urandom_range(3, 8);
    bN = $urandom_range(10, 16); bV = $urandom_range(1, 3);
    bD = $urandom_range(1, bL - 1);

    repeat (3) cycle(0, 0, 1);
    repeat (2) cycle(0, 0, 0);

    lost0 = lost_seen;
    repeat (5) frame(aL, aH, aN, aV, 0, -1, -1);
    check("lock_a", locked, 1);
    check("h_total_a", h_total, aL);
    check("h_sync_width_a", h_sync_width, aH);
    check("v_total_a", v_total, aN);
    check("v_sync_width_a", v_sync_width, aV);
    check("lost_a", lost_seen - lost0, 0);

    lost0 = lost_seen;
    frame(aL, aH, aN, aV, 0, aN / 2, -1);
    repeat (4) frame(aL, aH, aN, aV, 0, -1, -1);
`ifdef VGA_SYNC_MON_TOLERANCE_EN
    exp_lost = 0;
`else
    exp_lost = 1;
`endif
    check("lost_stretch", lost_seen - lost0, exp_lost);
    check("relock_stretch", locked, 1);
    check("h_total_stretch", h_total, aL);

    lost0 = lost_seen;
    repeat (4200) cycle(0, 0, 0);
    check("lost_timeout", lost_seen - lost0, 1);
    check("unlocked_timeout", locked, 0);
    check("hold_outputs", {h_total, h_sync_width, v_total, v_sync_width},
          {12'(aL), 12'(aH), 11'(aN), 11'(aV)});
    repeat (5) frame(aL, aH, aN, aV, 0, -1, -1);
    check("relock_timeout", locked, 1);

    repeat (6) frame(bL, bH, bN, bV, bD, -1, -1);
    check("lock_b", locked, 1);
    check("outputs_b", {h_total, h_sync_width, v_total, v_sync_width},
          {12'(bL), 12'(bH), 11'(bN), 11'(bV)});

    lost0 = lost_seen;
    for (int i = 0; i < 8; i++) frame(bL, bH, bN + ((i % 2 == 0) ? 1 : 0), bV, bD, -1, -1);
    check("alt_unlocked", locked, 0);
    check("alt_lost", lost_seen - lost0, 1);

    repeat (4) frame(bL, bH, bN, bV, bD, -1, -1);
    check("relock_alt", locked, 1);
    frame(bL, bH, bN, bV, bD, -1, (bN / 2) * bL + bL / 2);
    repeat (4) frame(bL, bH, bN, bV, bD, -1, -1);
    check("relock_reset", locked, 1);
    check("outputs_reset", {h_total, h_sync_width, v_total, v_sync_width},
          {12'(bL), 12'(bH), 11'(bN), 11'(bV)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
